// File: rtl/transaction_sequencer_if.sv
// transaction_sequencer_if: operand, handshake and datapath-control bundle for the transaction sequencer
interface transaction_sequencer_if;
  logic        start_i;
  logic        player_i;
  logic [7:0]  amount_i;
  logic [7:0]  key_i;
  logic        done_step_i;
  logic [47:0] result_i;
  logic [2:0]  process_o;
  logic        player_o;
  logic [7:0]  amount_o;
  logic [7:0]  key_o;
  logic        load_player_o;
  logic        load_key_o;
  logic        load_amount_o;
  logic        load_register_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [47:0] result_o;
  modport slave (
    input  start_i, player_i, amount_i, key_i, done_step_i, result_i,
    output process_o, player_o, amount_o, key_o, load_player_o, load_key_o,
           load_amount_o, load_register_o, busy_o, done_o, error_o, result_o
  );
  modport master (
    output start_i, player_i, amount_i, key_i, done_step_i, result_i,
    input  process_o, player_o, amount_o, key_o, load_player_o, load_key_o,
           load_amount_o, load_register_o, busy_o, done_o, error_o, result_o
  );
endinterface

// File: rtl/transaction_sequencer.sv
// transaction_sequencer: Moore FSM that latches operands and steps a datapath through NUM_STEPS process codes with per-step timeout
module transaction_sequencer #(
  parameter int NUM_STEPS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    rst,
  transaction_sequencer_if.slave bus
);
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] GAP   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERROR = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        player_q, player_d;
  logic [7:0]  amount_q, amount_d;
  logic [7:0]  key_q, key_d;
  logic        error_q, error_d;
  logic [47:0] result_q, result_d;
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    player_d = player_q;
    amount_d = amount_q;
    key_d    = key_q;
    error_d  = error_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        state_d  = LOAD;
        player_d = bus.player_i;
        amount_d = bus.amount_i;
        key_d    = bus.key_i;
        error_d  = 1'b0;
        step_d   = 3'd0;
      end
      LOAD: begin
        state_d = ISSUE;
        cnt_d   = '0;
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.done_step_i) begin
          if (step_q == 3'(NUM_STEPS - 1)) begin
            state_d  = DONE;
            result_d = bus.result_i;
          end else begin
            state_d = GAP;
            step_d  = step_q + 3'd1;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERROR;
          error_d = 1'b1;
        end
      end
      GAP: begin
        state_d = ISSUE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      cnt_q    <= '0;
      player_q <= 1'b0;
      amount_q <= '0;
      key_q    <= '0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      player_q <= player_d;
      amount_q <= amount_d;
      key_q    <= key_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end
  assign bus.process_o       = (state_q == ISSUE) ? step_q + 3'd1 : 3'd0;
  assign bus.player_o        = player_q;
  assign bus.amount_o        = amount_q;
  assign bus.key_o           = key_q;
  assign bus.load_player_o   = state_q == LOAD;
  assign bus.load_key_o      = state_q == LOAD;
  assign bus.load_amount_o   = state_q == LOAD;
  assign bus.load_register_o = state_q == LOAD;
  assign bus.busy_o          = state_q inside {LOAD, ISSUE, GAP, DONE};
  assign bus.done_o          = state_q == DONE;
  assign bus.error_o         = error_q;
  assign bus.result_o        = result_q;
endmodule

// File: tb/tb_transaction_sequencer.sv
// tb_transaction_sequencer: directed checks of the sequencer with default and short-timeout instances
module tb_transaction_sequencer;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int errs = 0;
  int pexp [7] = '{1, 0, 2, 0, 3, 0, 4};
  transaction_sequencer_if b0 ();
  transaction_sequencer_if b1 ();
  transaction_sequencer u0 (.clk(clk), .rst(rst), .bus(b0));
  transaction_sequencer #(.TIMEOUT_CYCLES(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] loads0();
    return {b0.load_player_o, b0.load_key_o, b0.load_amount_o, b0.load_register_o};
  endfunction
  function automatic logic [16:0] ops0();
    return {b0.player_o, b0.amount_o, b0.key_o};
  endfunction
  initial begin
    rst = 1'b1;
    {b0.start_i, b0.player_i, b0.amount_i, b0.key_i, b0.done_step_i, b0.result_i} = '0;
    {b1.start_i, b1.player_i, b1.amount_i, b1.key_i, b1.done_step_i, b1.result_i} = '0;
    tick();
    tick();
    chk("rst_process", 48'(b0.process_o), 0);
    chk("rst_ops", 48'(ops0()), 0);
    chk("rst_loads", 48'(loads0()), 0);
    chk("rst_flags", 48'({b0.busy_o, b0.done_o, b0.error_o}), 0);
    chk("rst_result", b0.result_o, 0);
    chk("rst_u1_flags", 48'({b1.busy_o, b1.done_o, b1.error_o, b1.process_o}), 0);
    rst = 1'b0;
    b0.start_i = 1'b1;
    b0.player_i = 1'b1;
    b0.amount_i = 8'h05;
    b0.key_i = 8'hA3;
    b0.done_step_i = 1'b1;
    b0.result_i = 48'h0280_0200_0120;
    chk("nom_idle_busy", 48'(b0.busy_o), 0);
    tick();
    b0.start_i = 1'b0;
    chk("nom_load_strobes", 48'(loads0()), 48'hF);
    chk("nom_load_busy", 48'(b0.busy_o), 1);
    chk("nom_load_process", 48'(b0.process_o), 0);
    chk("nom_operands", 48'(ops0()), 48'({1'b1, 8'h05, 8'hA3}));
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("nom_process", 48'(b0.process_o), 48'(pexp[i]));
      chk("nom_busy", 48'({b0.busy_o, b0.done_o}), 48'b10);
    end
    tick();
    chk("nom_done", 48'({b0.done_o, b0.busy_o, b0.error_o}), 48'b110);
    chk("nom_result", b0.result_o, 48'h0280_0200_0120);
    tick();
    chk("nom_after_done", 48'({b0.done_o, b0.busy_o}), 0);
    chk("nom_result_hold", b0.result_o, 48'h0280_0200_0120);
    b0.start_i = 1'b1;
    b0.result_i = 48'h1234_5678_9ABC;
    tick();
    b0.start_i = 1'b0;
    tick();
    chk("stall_p1", 48'(b0.process_o), 1);
    tick();
    chk("stall_gap1", 48'(b0.process_o), 0);
    b0.done_step_i = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_p2_hold", 48'(b0.process_o), 2);
      tick();
    end
    chk("stall_p2_last", 48'({b0.process_o, b0.busy_o}), 48'({3'd2, 1'b1}));
    b0.done_step_i = 1'b1;
    tick();
    chk("stall_gap2", 48'({b0.process_o, b0.busy_o}), 48'({3'd0, 1'b1}));
    tick();
    chk("stall_p3", 48'(b0.process_o), 3);
    tick();
    tick();
    chk("stall_p4", 48'(b0.process_o), 4);
    tick();
    chk("stall_done", 48'(b0.done_o), 1);
    chk("stall_result", b0.result_o, 48'h1234_5678_9ABC);
    tick();
    b0.start_i = 1'b1;
    b0.player_i = 1'b0;
    b0.amount_i = 8'h11;
    b0.key_i = 8'h22;
    b0.result_i = 48'hAAAA_BBBB_CCCC;
    tick();
    b0.amount_i = 8'h99;
    b0.player_i = 1'b1;
    b0.key_i = 8'h77;
    repeat (7) tick();
    chk("hold_p4", 48'(b0.process_o), 4);
    tick();
    chk("hold_done", 48'(b0.done_o), 1);
    chk("hold_operands", 48'(ops0()), 48'({1'b0, 8'h11, 8'h22}));
    chk("hold_result", b0.result_o, 48'hAAAA_BBBB_CCCC);
    tick();
    chk("hold_idle", 48'({b0.busy_o, b0.done_o, loads0()}), 0);
    tick();
    b0.start_i = 1'b0;
    chk("hold_restart_load", 48'(loads0()), 48'hF);
    chk("hold_restart_ops", 48'(ops0()), 48'({1'b1, 8'h99, 8'h77}));
    tick();
    tick();
    tick();
    chk("rst_mid_p2", 48'(b0.process_o), 2);
    tick();
    chk("rst_mid_gap", 48'({b0.process_o, b0.busy_o}), 48'({3'd0, 1'b1}));
    rst = 1'b1;
    b0.start_i = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_process", 48'(b0.process_o), 0);
    chk("rst_mid_ops", 48'(ops0()), 0);
    chk("rst_mid_flags", 48'({b0.busy_o, b0.done_o, b0.error_o, loads0()}), 0);
    chk("rst_mid_result", b0.result_o, 0);
    tick();
    b0.start_i = 1'b0;
    chk("rst_mid_load", 48'(loads0()), 48'hF);
    tick();
    chk("rst_mid_step1", 48'(b0.process_o), 1);
    b1.start_i = 1'b1;
    b1.result_i = 48'hDEAD_BEEF_0001;
    tick();
    b1.start_i = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_issue_p1", 48'({b1.process_o, b1.error_o}), 48'({3'd1, 1'b0}));
      tick();
    end
    chk("to_error_flags", 48'({b1.error_o, b1.busy_o, b1.done_o}), 48'b100);
    chk("to_error_process", 48'(b1.process_o), 0);
    chk("to_error_result", b1.result_o, 0);
    tick();
    chk("to_idle_sticky", 48'({b1.error_o, b1.busy_o}), 48'b10);
    b1.start_i = 1'b1;
    tick();
    b1.start_i = 1'b0;
    chk("to_restart_clear", 48'({b1.error_o, b1.load_register_o}), 48'b01);
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("exp_p1", 48'(b1.process_o), 1);
      tick();
    end
    chk("exp_last_cycle", 48'(b1.process_o), 1);
    b1.done_step_i = 1'b1;
    tick();
    chk("exp_gap", 48'({b1.process_o, b1.busy_o, b1.error_o}), 48'({3'd0, 2'b10}));
    tick();
    chk("exp_p2", 48'(b1.process_o), 2);
    repeat (4) tick();
    chk("exp_p4", 48'(b1.process_o), 4);
    tick();
    chk("exp_done", 48'({b1.done_o, b1.error_o}), 48'b10);
    chk("exp_result", b1.result_o, 48'hDEAD_BEEF_0001);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/transaction_sequencer.md
TRANSACTION_SEQUENCER -- requirements
Module: transaction_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 4, number of process steps per transaction (1..7).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum ISSUE cycles allowed per step before an error is raised.
REQ-003 Port clock, input, 1, the single clock; all logic SHALL be rising-edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, request a transaction; sampled only in IDLE.
REQ-006 Port player_in, input, 1, player select operand.
REQ-007 Port amount_in, input, 8, amount operand.
REQ-008 Port key_in, input, 8, key operand.
REQ-009 Port done_step, input, 1, step completion from the datapath.
REQ-010 Port result_in, input, 48, datapath result bus.
REQ-011 Port process, output, 3, step code presented to the datapath; 0 means no operation.
REQ-012 Port player_out, output, 1, latched player operand.
REQ-013 Port amount_out, output, 8, latched amount operand.
REQ-014 Port key_out, output, 8, latched key operand.
REQ-015 Ports load_player, load_key, load_amount, load_register, output, 1 each, datapath load strobes.
REQ-016 Port busy, output, 1, transaction in progress.
REQ-017 Port done, output, 1, one-cycle completion pulse.
REQ-018 Port error, output, 1, sticky timeout flag.
REQ-019 Port result_out, output, 48, captured result.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, ISSUE, GAP, DONE and ERROR; all outputs SHALL be Moore, decoded from state and registers.
REQ-021 In IDLE with start=1, the block SHALL latch player_in, amount_in and key_in into player_out, amount_out and key_out, clear error, clear the step index, and move to LOAD.
REQ-022 LOAD SHALL last exactly 1 cycle, assert load_player, load_key, load_amount and load_register together, then move to ISSUE.
REQ-023 ISSUE SHALL drive process = step index + 1 and increment the timeout counter every cycle; the counter SHALL clear on entry to each ISSUE.
REQ-024 done_step=1 sampled in ISSUE with step index < NUM_STEPS-1 SHALL increment the step index and move to GAP.
REQ-025 GAP SHALL last exactly 1 cycle with process=0, then move to ISSUE.
REQ-026 done_step=1 sampled in ISSUE on the last step SHALL capture result_in into result_out on that edge and move to DONE.
REQ-027 DONE SHALL assert done for exactly 1 cycle, then move to IDLE.
REQ-028 In ISSUE, if the counter reaches TIMEOUT_CYCLES with done_step=0, the block SHALL move to ERROR; done_step=1 in the expiry cycle SHALL win over the timeout.
REQ-029 ERROR SHALL set error=1 and process=0, leave result_out unchanged, and move to IDLE the next cycle; error SHALL remain 1 until the next accepted start.
REQ-030 busy SHALL be 1 in LOAD, ISSUE, GAP and DONE, and 0 in IDLE and ERROR.
REQ-031 start SHALL be ignored outside IDLE; changes on the operand inputs outside the IDLE acceptance cycle SHALL NOT affect the latched operands.
REQ-032 done_step outside ISSUE SHALL be ignored.
REQ-033 result_out SHALL change only in the REQ-026 cycle and on reset.

Reset
REQ-034 reset=1 at a clock edge SHALL force IDLE from any state, including mid-transaction.
REQ-035 On reset, all of the following SHALL be 0: process, the operand outputs, the load strobes, busy, done, error, result_out, the step index and the timeout counter.
REQ-036 reset SHALL take priority over start and done_step in the same cycle.

Verification
REQ-037 Nominal: start at cycle 0 with player=1, amount=0x05, key=0xA3, and done_step=1 in every ISSUE cycle with result_in=0x0280_0200_0120 -> LOAD strobes at cycle 1; process=1,0,2,0,3,0,4 on cycles 2..8; result_out=0x0280_0200_0120 and done=1 at cycle 9; busy=1 on cycles 1..9.
REQ-038 Stalled step: done_step withheld for 10 cycles on step 2 -> process=2 held for 11 cycles; no GAP entered early; transaction completes normally.
REQ-039 Timeout: TIMEOUT_CYCLES=8 and done_step never asserted -> ERROR after 8 ISSUE cycles; error=1, busy=0, process=0, result_out unchanged; the next start clears error.
REQ-040 done_step asserted in the timeout-expiry cycle -> step advances, no error.
REQ-041 start held high for the whole transaction and amount_in changed mid-run -> exactly one transaction runs with the original amount_out; a new transaction starts on the cycle after DONE.
REQ-042 reset asserted during GAP of step 2 -> all outputs 0 on the next cycle and state IDLE; a following start runs from step 1.
